// File: rtl/oled_pkg.sv
// Shared types and helpers for the OLED text refresher: FSM state encoding,
// glyph geometry and the controller base-address packing.
package oled_pkg;

   localparam int CHAR_PX     = 8;  // glyph width in pixels
   localparam int BASE_ADDR_W = 9;  // controller local-memory base address width

   typedef enum logic [3:0] {
      ST_OFF,
      ST_PWR_ON,
      ST_IDLE,
      ST_RD,
      ST_WR,
      ST_WR_WAIT,
      ST_UPD,
      ST_UPD_WAIT,
      ST_PWR_OFF
   } oled_state_t;

   // Controller base address of a character cell: {row, col, pixel offset 0}.
   function automatic logic [BASE_ADDR_W-1:0] pack_base_addr(input logic [1:0] row,
                                                            input logic [3:0] col);
      return {row, col, {$clog2(CHAR_PX){1'b0}}};
   endfunction

endpackage

// File: rtl/oled_char_cursor.sv
// Character cursor: row/column counters plus a running linear RAM address
// (row*COLS+col) that is stepped instead of multiplied. 'last' flags the
// final cell of the frame.
module oled_char_cursor #(
   parameter int ROWS   = 4,
   parameter int COLS   = 16,
   parameter int ADDR_W = 6
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              clear,
   input  logic              step,
   output logic [1:0]        row,
   output logic [3:0]        col,
   output logic [ADDR_W-1:0] lin,
   output logic              last
);

   localparam logic [1:0] ROW_LAST = 2'(ROWS - 1);
   localparam logic [3:0] COL_LAST = 4'(COLS - 1);

   logic col_wrap;

   assign col_wrap = (col == COL_LAST);
   assign last     = col_wrap && (row == ROW_LAST);

   // Advance column, wrap into the next row, and keep the linear address in step.
   always_ff @(posedge clk) begin
      // NOTE: sequential state uses non-blocking assignments so every register
      // samples pre-edge values regardless of statement order.
      if (rst || clear) begin
         row <= '0;
         col <= '0;
         lin <= '0;
      end else if (step) begin
         lin <= lin + 1'b1;
         if (col_wrap) begin
            col <= '0;
            row <= row + 2'd1;
         end else begin
            col <= col + 4'd1;
         end
      end
   end

endmodule

// File: rtl/oled_text_refresher.sv
// OLED text refresher: streams a ROWS x COLS ASCII buffer from a sync-read
// text RAM into an OLED controller's char-write/update interface, and drives
// the panel power sequence from the display_en level. A frame is sent only
// when the buffer is dirty (host write or power-on).
// Optional feature macro: OLED_AUTO_REFRESH_EN -- periodic refresh from an
// IDLE cycle counter every REFRESH_CYCLES cycles.
module oled_text_refresher
   import oled_pkg::*;
#(
   parameter int ROWS           = 4,
   parameter int COLS           = 16,
   parameter int ADDR_W         = 6,
   parameter int REFRESH_CYCLES = 2**20
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   display_en,
   input  logic                   buf_wr,
   output logic [ADDR_W-1:0]      ram_addr,
   input  logic [7:0]             ram_data,
   output logic                   write_start,
   output logic [7:0]             write_ascii,
   output logic [BASE_ADDR_W-1:0] write_base_addr,
   input  logic                   write_ready,
   output logic                   update_start,
   input  logic                   update_ready,
   output logic                   disp_on_start,
   input  logic                   disp_on_ready,
   output logic                   disp_off_start,
   input  logic                   disp_off_ready,
   output logic                   busy,
   output logic                   frame_done
);

   // Reject parameter sets the base-address packing cannot represent.
   if (ROWS < 1 || ROWS > 4 || COLS < 1 || COLS > 16 ||
       ROWS * COLS > 2**ADDR_W || REFRESH_CYCLES < 1) begin : g_param_check
      $error("oled_text_refresher: illegal parameter set");
   end

   oled_state_t state, state_d;

   logic       dirty;
   logic       busy_seen;     // controller dropped ready since the last start pulse
   logic       in_wait;
   logic       ready_sel;
   logic       done;
   logic       fire_on, fire_off, fire_wr, fire_upd;
   logic       frame_done_d;
   logic       dirty_clr, dirty_force, refresh_hit;
   logic       cur_clear, cur_step, cur_last;
   logic [1:0] cur_row;
   logic [3:0] cur_col;

   oled_char_cursor #(
      .ROWS   (ROWS),
      .COLS   (COLS),
      .ADDR_W (ADDR_W)
   ) u_cursor (
      .clk   (clk),
      .rst   (rst),
      .clear (cur_clear),
      .step  (cur_step),
      .row   (cur_row),
      .col   (cur_col),
      .lin   (ram_addr),
      .last  (cur_last)
   );

   assign busy = (state != ST_OFF) && (state != ST_IDLE);

   // Select the ready line of the handshake the current wait state tracks.
   always_comb begin
      // NOTE: every combinational output gets a default first, so no path
      // through the case can leave it unassigned and infer a latch.
      in_wait   = 1'b1;
      ready_sel = 1'b0;
      unique case (state)
         ST_PWR_ON:   ready_sel = disp_on_ready;
         ST_WR_WAIT:  ready_sel = write_ready;
         ST_UPD_WAIT: ready_sel = update_ready;
         ST_PWR_OFF:  ready_sel = disp_off_ready;
         default:     in_wait   = 1'b0;
      endcase
   end

   // A handshake completes once ready has dropped and come back.
   assign done = in_wait && busy_seen && ready_sel;

   // Next-state and per-cycle control decisions.
   always_comb begin
      state_d      = state;
      fire_on      = 1'b0;
      fire_off     = 1'b0;
      fire_wr      = 1'b0;
      fire_upd     = 1'b0;
      frame_done_d = 1'b0;
      dirty_clr    = 1'b0;
      dirty_force  = 1'b0;
      cur_clear    = 1'b0;
      cur_step     = 1'b0;
      unique case (state)
         ST_OFF: begin
            if (display_en && disp_on_ready) begin
               fire_on = 1'b1;
               state_d = ST_PWR_ON;
            end
         end
         ST_PWR_ON: begin
            if (done) begin
               dirty_force = 1'b1;
               state_d     = ST_IDLE;
            end
         end
         ST_IDLE: begin
            if (!display_en) begin
               if (disp_off_ready) begin
                  fire_off = 1'b1;
                  state_d  = ST_PWR_OFF;
               end
            end else if (dirty) begin
               dirty_clr = 1'b1;
               cur_clear = 1'b1;
               state_d   = ST_RD;
            end
         end
         ST_RD: begin
            // Power-down abandons the frame; keep it dirty for the next power-up.
            if (!display_en) begin
               dirty_force = 1'b1;
               state_d     = ST_IDLE;
            end else begin
               state_d = ST_WR;
            end
         end
         ST_WR: begin
            if (!display_en) begin
               dirty_force = 1'b1;
               state_d     = ST_IDLE;
            end else if (write_ready) begin
               fire_wr = 1'b1;
               state_d = ST_WR_WAIT;
            end
         end
         ST_WR_WAIT: begin
            if (done) begin
               if (!display_en) begin
                  dirty_force = 1'b1;
                  state_d     = ST_IDLE;
               end else if (cur_last) begin
                  state_d = ST_UPD;
               end else begin
                  cur_step = 1'b1;
                  state_d  = ST_RD;
               end
            end
         end
         ST_UPD: begin
            if (!display_en) begin
               dirty_force = 1'b1;
               state_d     = ST_IDLE;
            end else if (update_ready) begin
               fire_upd = 1'b1;
               state_d  = ST_UPD_WAIT;
            end
         end
         ST_UPD_WAIT: begin
            if (done) begin
               frame_done_d = 1'b1;
               state_d      = ST_IDLE;
            end
         end
         ST_PWR_OFF: begin
            if (done) state_d = ST_OFF;
         end
         default: state_d = ST_OFF;
      endcase
   end

`ifdef OLED_AUTO_REFRESH_EN
   localparam int RC_W = $clog2(REFRESH_CYCLES + 1);
   localparam logic [RC_W-1:0] RC_LAST = RC_W'(REFRESH_CYCLES - 1);

   logic [RC_W-1:0] refresh_cnt;

   assign refresh_hit = (state == ST_IDLE) && (refresh_cnt == RC_LAST);

   // Count IDLE cycles; restart on every frame start and after each refresh.
   always_ff @(posedge clk) begin
      if (rst || dirty_clr || refresh_hit) refresh_cnt <= '0;
      else if (state == ST_IDLE)           refresh_cnt <= refresh_cnt + 1'b1;
   end
`else
   assign refresh_hit = 1'b0;
`endif

   // State register and handshake tracking.
   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= ST_OFF;
         busy_seen <= 1'b0;
      end else begin
         state <= state_d;
         if (fire_on || fire_off || fire_wr || fire_upd || done) busy_seen <= 1'b0;
         else if (in_wait && !ready_sel)                         busy_seen <= 1'b1;
      end
   end

   // Dirty flag: any set source wins over the frame-start clear.
   always_ff @(posedge clk) begin
      if (rst)                                       dirty <= 1'b1;
      else if (buf_wr || dirty_force || refresh_hit) dirty <= 1'b1;
      else if (dirty_clr)                            dirty <= 1'b0;
   end

   // Registered one-cycle start pulses and the latched write payload.
   always_ff @(posedge clk) begin
      if (rst) begin
         write_start     <= 1'b0;
         update_start    <= 1'b0;
         disp_on_start   <= 1'b0;
         disp_off_start  <= 1'b0;
         frame_done      <= 1'b0;
         write_ascii     <= '0;
         write_base_addr <= '0;
      end else begin
         write_start    <= fire_wr;
         update_start   <= fire_upd;
         disp_on_start  <= fire_on;
         disp_off_start <= fire_off;
         frame_done     <= frame_done_d;
         if (fire_wr) begin
            write_ascii     <= ram_data;
            write_base_addr <= pack_base_addr(cur_row, cur_col);
         end
      end
   end

endmodule

// File: tb/tb_oled_text_refresher.sv
// Directed self-checking bench for oled_text_refresher. Instance A is the
// 4x16 configuration, instance B a 2x5 configuration; each has its own text
// RAM and a controller model that goes busy for a few cycles per start pulse.
module tb_oled_text_refresher;
   import oled_pkg::*;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic rst;
   int   checks   = 0;
   int   failures = 0;

   // ---------------- instance A: ROWS=4, COLS=16 ----------------
   logic       a_display_en, a_buf_wr;
   logic [5:0] a_ram_addr;
   logic [7:0] a_ram_data;
   logic       a_write_start, a_update_start, a_disp_on_start, a_disp_off_start;
   logic [7:0] a_write_ascii;
   logic [8:0] a_write_base_addr;
   logic       a_busy, a_frame_done, a_ready;

   oled_text_refresher #(.ROWS(4), .COLS(16), .ADDR_W(6)) dut_a (
      .clk             (clk),
      .rst             (rst),
      .display_en      (a_display_en),
      .buf_wr          (a_buf_wr),
      .ram_addr        (a_ram_addr),
      .ram_data        (a_ram_data),
      .write_start     (a_write_start),
      .write_ascii     (a_write_ascii),
      .write_base_addr (a_write_base_addr),
      .write_ready     (a_ready),
      .update_start    (a_update_start),
      .update_ready    (a_ready),
      .disp_on_start   (a_disp_on_start),
      .disp_on_ready   (a_ready),
      .disp_off_start  (a_disp_off_start),
      .disp_off_ready  (a_ready),
      .busy            (a_busy),
      .frame_done      (a_frame_done)
   );

   logic [7:0] a_ram [0:63];
   int         a_up, a_lat;

   // Text RAM A with 1-cycle synchronous read.
   always @(posedge clk) a_ram_data <= a_ram[a_ram_addr];

   // Controller model A: ready 10 cycles after reset, busy 3 cycles per start.
   always @(posedge clk) begin
      if (rst) begin
         a_up  <= 0;
         a_lat <= 0;
      end else begin
         if (a_up < 10) a_up <= a_up + 1;
         if (a_write_start || a_update_start || a_disp_on_start || a_disp_off_start) a_lat <= 3;
         else if (a_lat > 0) a_lat <= a_lat - 1;
      end
   end
   assign a_ready = (a_up >= 10) && (a_lat == 0);

   int         a_wr_cnt = 0, a_upd_cnt = 0, a_on_cnt = 0, a_off_cnt = 0, a_fd_cnt = 0;
   logic [7:0] a_wr_ascii [0:511];
   logic [8:0] a_wr_base  [0:511];

   // Monitor A: log pulses and write payloads between clock edges.
   always @(negedge clk) begin
      if (a_write_start) begin
         if (a_wr_cnt < 512) begin
            a_wr_ascii[a_wr_cnt] <= a_write_ascii;
            a_wr_base[a_wr_cnt]  <= a_write_base_addr;
         end
         a_wr_cnt <= a_wr_cnt + 1;
      end
      if (a_update_start)   a_upd_cnt <= a_upd_cnt + 1;
      if (a_disp_on_start)  a_on_cnt  <= a_on_cnt + 1;
      if (a_disp_off_start) a_off_cnt <= a_off_cnt + 1;
      if (a_frame_done)     a_fd_cnt  <= a_fd_cnt + 1;
   end

   // ---------------- instance B: ROWS=2, COLS=5 ----------------
   logic       b_display_en, b_buf_wr;
   logic [3:0] b_ram_addr;
   logic [7:0] b_ram_data;
   logic       b_write_start, b_update_start, b_disp_on_start, b_disp_off_start;
   logic [7:0] b_write_ascii;
   logic [8:0] b_write_base_addr;
   logic       b_busy, b_frame_done, b_ready;

   oled_text_refresher #(.ROWS(2), .COLS(5), .ADDR_W(4)) dut_b (
      .clk             (clk),
      .rst             (rst),
      .display_en      (b_display_en),
      .buf_wr          (b_buf_wr),
      .ram_addr        (b_ram_addr),
      .ram_data        (b_ram_data),
      .write_start     (b_write_start),
      .write_ascii     (b_write_ascii),
      .write_base_addr (b_write_base_addr),
      .write_ready     (b_ready),
      .update_start    (b_update_start),
      .update_ready    (b_ready),
      .disp_on_start   (b_disp_on_start),
      .disp_on_ready   (b_ready),
      .disp_off_start  (b_disp_off_start),
      .disp_off_ready  (b_ready),
      .busy            (b_busy),
      .frame_done      (b_frame_done)
   );

   logic [7:0] b_ram [0:15];
   int         b_lat;

   // Text RAM B with 1-cycle synchronous read.
   always @(posedge clk) b_ram_data <= b_ram[b_ram_addr];

   // Controller model B: always up, busy 2 cycles per start.
   always @(posedge clk) begin
      if (rst) b_lat <= 0;
      else if (b_write_start || b_update_start || b_disp_on_start || b_disp_off_start) b_lat <= 2;
      else if (b_lat > 0) b_lat <= b_lat - 1;
   end
   assign b_ready = (b_lat == 0);

   int         b_wr_cnt = 0, b_fd_cnt = 0;
   logic [7:0] b_wr_ascii [0:63];
   logic [8:0] b_wr_base  [0:63];
   logic [3:0] b_wr_addr  [0:63];

   // Monitor B: log write payloads and the RAM address of each written char.
   always @(negedge clk) begin
      if (b_write_start) begin
         if (b_wr_cnt < 64) begin
            b_wr_ascii[b_wr_cnt] <= b_write_ascii;
            b_wr_base[b_wr_cnt]  <= b_write_base_addr;
            b_wr_addr[b_wr_cnt]  <= b_ram_addr;
         end
         b_wr_cnt <= b_wr_cnt + 1;
      end
      if (b_frame_done) b_fd_cnt <= b_fd_cnt + 1;
   end

   // ---------------- checking helpers ----------------
   task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      checks++;
      assert (observed === expected) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, observed, expected);
      end
   endtask

   task automatic tick(input int n);
      for (int i = 0; i < n; i++) begin
         @(negedge clk);
         #1;
      end
   endtask

   int w0, f0, u0, on0, off0;

   // ---------------- directed sequence ----------------
   initial begin
      for (int i = 0; i < 64; i++) begin
         if (i < 16)      a_ram[i] = 8'h60 + 8'(i);
         else if (i < 32) a_ram[i] = 8'h41 + 8'(i - 16);
         else             a_ram[i] = 8'h20 + 8'(i);
      end
      for (int i = 0; i < 16; i++) b_ram[i] = 8'h30 + 8'(i);

      rst          = 1'b1;
      a_display_en = 1'b0;
      a_buf_wr     = 1'b0;
      b_display_en = 1'b1;
      b_buf_wr     = 1'b0;
      tick(3);

      // T1: reset state
      check("rst_state",    32'(dut_a.state), 32'(ST_OFF));
      check("rst_busy",     32'(a_busy), 32'd0);
      check("rst_outputs",  32'({a_write_start, a_update_start, a_disp_on_start,
                                 a_disp_off_start, a_frame_done}), 32'd0);
      check("rst_ram_addr", 32'(a_ram_addr), 32'd0);
      check("rst_dirty",    32'(dut_a.dirty), 32'd1);

      rst          = 1'b0;
      a_display_en = 1'b1;
      for (int i = 0; i < 3000 && a_fd_cnt < 1; i++) tick(1);
      tick(2);
      check("t1_frame_done_cnt", a_fd_cnt, 1);
      check("t1_disp_on_cnt",    a_on_cnt, 1);
      check("t1_write_cnt",      a_wr_cnt, 64);
      check("t1_update_cnt",     a_upd_cnt, 1);
      check("t1_first_base",     32'(a_wr_base[0]), 32'h000);
      check("t1_last_base",      32'(a_wr_base[63]), 32'h1F8);
      check("t1_first_ascii",    32'(a_wr_ascii[0]), 32'h60);
      check("t1_idle_state",     32'(dut_a.state), 32'(ST_IDLE));
      check("t1_idle_busy",      32'(a_busy), 32'd0);

      // T2: row 1 holds "A".."P"
      check("t2_row1_first_ascii", 32'(a_wr_ascii[16]), 32'h41);
      check("t2_row1_first_base",  32'(a_wr_base[16]),  32'h080);
      check("t2_row1_last_ascii",  32'(a_wr_ascii[31]), 32'h50);
      check("t2_row1_last_base",   32'(a_wr_base[31]),  32'h0F8);

      // T3: buf_wr during char 20 produces exactly one extra frame
      w0 = a_wr_cnt;
      f0 = a_fd_cnt;
      a_buf_wr = 1'b1;
      tick(1);
      a_buf_wr = 1'b0;
      for (int i = 0; i < 3000 && a_wr_cnt < w0 + 21; i++) tick(1);
      check("t3_reach_char20", a_wr_cnt, w0 + 21);
      a_buf_wr = 1'b1;
      tick(1);
      a_buf_wr = 1'b0;
      for (int i = 0; i < 3000 && a_fd_cnt < f0 + 2; i++) tick(1);
      tick(300);
      check("t3_frames",     a_fd_cnt, f0 + 2);
      check("t3_writes",     a_wr_cnt, w0 + 128);
      check("t3_idle_state", 32'(dut_a.state), 32'(ST_IDLE));
      check("t3_idle_busy",  32'(a_busy), 32'd0);

      // T4: display_en drops during char 30
      w0   = a_wr_cnt;
      f0   = a_fd_cnt;
      u0   = a_upd_cnt;
      on0  = a_on_cnt;
      off0 = a_off_cnt;
      a_buf_wr = 1'b1;
      tick(1);
      a_buf_wr = 1'b0;
      for (int i = 0; i < 3000 && a_wr_cnt < w0 + 31; i++) tick(1);
      a_display_en = 1'b0;
      for (int i = 0; i < 500 && dut_a.state != ST_OFF; i++) tick(1);
      tick(5);
      check("t4_writes",    a_wr_cnt, w0 + 31);
      check("t4_no_update", a_upd_cnt, u0);
      check("t4_no_frame",  a_fd_cnt, f0);
      check("t4_off_cnt",   a_off_cnt, off0 + 1);
      check("t4_state_off", 32'(dut_a.state), 32'(ST_OFF));
      check("t4_busy_off",  32'(a_busy), 32'd0);
      a_display_en = 1'b1;
      for (int i = 0; i < 3000 && a_fd_cnt < f0 + 1; i++) tick(1);
      tick(2);
      check("t4_on_cnt",          a_on_cnt, on0 + 1);
      check("t4_reenable_frame",  a_fd_cnt, f0 + 1);
      check("t4_reenable_writes", a_wr_cnt, w0 + 31 + 64);
      check("t4_reenable_update", a_upd_cnt, u0 + 1);

      // T5: 2x5 instance, first frame after power-on
      for (int i = 0; i < 2000 && b_fd_cnt < 1; i++) tick(1);
      check("t5_frames",     b_fd_cnt, 1);
      check("t5_writes",     b_wr_cnt, 10);
      check("t5_row1_base",  32'(b_wr_base[5]), 32'h080);
      check("t5_last_base",  32'(b_wr_base[9]), 32'h0A0);
      check("t5_last_ascii", 32'(b_wr_ascii[9]), 32'h39);
      for (int i = 0; i < 10; i++) check($sformatf("t5_ram_addr_%0d", i), 32'(b_wr_addr[i]), i);

      // T6: reset while a write is outstanding
      w0 = a_wr_cnt;
      a_buf_wr = 1'b1;
      tick(1);
      a_buf_wr = 1'b0;
      for (int i = 0; i < 500 && a_wr_cnt < w0 + 1; i++) tick(1);
      check("t6_in_wr_wait", 32'(dut_a.state), 32'(ST_WR_WAIT));
      rst = 1'b1;
      tick(1);
      check("t6_state_off", 32'(dut_a.state), 32'(ST_OFF));
      check("t6_outputs", 32'({a_write_start, a_write_ascii, a_write_base_addr, a_update_start,
                               a_disp_on_start, a_disp_off_start, a_busy, a_frame_done,
                               a_ram_addr}), 32'd0);
      rst = 1'b0;
      tick(2);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
